// File: rtl/vend_pkg.sv
// Shared encodings for the vending session controller: core states,
// product code range, coin denominations and the controller state enum.
package vend_pkg;

    // Vending core state encodings as reported on i_vm_state
    localparam logic [3:0] VM_IDLE     = 4'd0;
    localparam logic [3:0] VM_SELECT   = 4'd1;
    localparam logic [3:0] VM_PROD_LO  = 4'd2;
    localparam logic [3:0] VM_PROD_HI  = 4'd6;
    localparam logic [3:0] VM_DISPENSE = 4'd7;

    // Highest legal product code (codes 0..4)
    localparam logic [2:0] PROD_MAX = 3'd4;

    // Coin denomination values, indexed by the 2-bit denomination code
    localparam logic [6:0] COIN0 = 7'd5;
    localparam logic [6:0] COIN1 = 7'd10;
    localparam logic [6:0] COIN2 = 7'd20;
    localparam logic [6:0] COIN3 = 7'd50;

    // Last watchdog count in WAIT_SEL before the core is declared stuck
    localparam logic [1:0] WD_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_SEL = 3'd2,
        ST_PAY      = 3'd3,
        ST_PAYOUT   = 3'd4
    } ctrl_state_t;

    // Value in credit units of a denomination code
    function automatic logic [6:0] coin_value(input logic [1:0] denom);
        logic [6:0] v;
        case (denom)
            2'd0:    v = COIN0;
            2'd1:    v = COIN1;
            2'd2:    v = COIN2;
            2'd3:    v = COIN3;
            default: v = COIN0;
        endcase
        return v;
    endfunction

    // Largest denomination not exceeding the amount (amount >= COIN0 assumed)
    function automatic logic [1:0] greedy_denom(input logic [6:0] amount);
        logic [1:0] d;
        if (amount >= COIN3) begin
            d = 2'd3;
        end else if (amount >= COIN2) begin
            d = 2'd2;
        end else if (amount >= COIN1) begin
            d = 2'd1;
        end else begin
            d = 2'd0;
        end
        return d;
    endfunction

endpackage

// File: rtl/vend_change_payout.sv
// Greedy change dispenser: loaded with an amount, it offers one coin at a
// time over valid/ready, biggest denomination first, then reports done, or
// fault if a residue smaller than the smallest coin is left.
module vend_change_payout
    import vend_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [6:0] i_amount,
    input  logic       i_chg_ready,
    output logic       o_chg_valid,
    output logic [1:0] o_chg_denom,
    output logic       o_done,
    output logic       o_fault
);

    logic [6:0] r_remaining;
    logic       r_active;
    logic       r_valid;
    logic [1:0] r_denom;
    logic       r_done;
    logic       r_fault;

    // Payout sequencing: load, offer coin, hold until accepted, subtract, repeat
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_remaining <= 7'd0;
            r_active    <= 1'b0;
            r_valid     <= 1'b0;
            r_denom     <= 2'd0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            if (i_load) begin
                r_remaining <= i_amount;
                r_active    <= 1'b1;
                r_valid     <= 1'b0;
            end else if (r_valid) begin
                // denom and valid stay frozen until the hopper takes the coin
                if (i_chg_ready) begin
                    r_remaining <= r_remaining - coin_value(r_denom);
                    r_valid     <= 1'b0;
                end
            end else if (r_active) begin
                if (r_remaining == 7'd0) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end else if (r_remaining < COIN0) begin
                    // residue cannot be paid out; drop it and flag
                    r_active    <= 1'b0;
                    r_fault     <= 1'b1;
                    r_remaining <= 7'd0;
                end else begin
                    r_valid <= 1'b1;
                    r_denom <= greedy_denom(r_remaining);
                end
            end
        end
    end

    assign o_chg_valid = r_valid;
    assign o_chg_denom = r_denom;
    assign o_done      = r_done;
    assign o_fault     = r_fault;

endmodule

// File: rtl/vend_session_ctrl.sv
// Session sequencer between the front panel / coin mech and the vending
// core: latches the selection, accumulates credit, handles cancel/timeout
// and the core's dispense result, then pays change out coin by coin.
module vend_session_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [6:0]  MAX_CREDIT     = 7'd127
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sel_valid,
    input  logic [2:0] i_sel_code,
    input  logic       i_coin_valid,
    input  logic [1:0] i_coin_denom,
    input  logic       i_cancel,
    input  logic       i_online_pay,
    input  logic [3:0] i_vm_state,
    input  logic       i_vm_dispense,
    input  logic [6:0] i_vm_return_change,
    output logic       o_vm_start,
    output logic       o_vm_cancel,
    output logic [2:0] o_vm_product_code,
    output logic       o_vm_online_payment,
    output logic [6:0] o_vm_total_coin_value,
    output logic       o_coin_reject,
    output logic       o_sel_error,
    output logic       o_busy,
    output logic       o_chg_valid,
    output logic [1:0] o_chg_denom,
    input  logic       i_chg_ready,
    output logic       o_fault
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1);
    localparam logic [TW-1:0] TMO_ZERO   = TW'(0);

    ctrl_state_t   r_state, w_state_nxt;
    logic [2:0]    r_code, w_code_nxt;
    logic [6:0]    r_credit, w_credit_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic [1:0]    r_wd, w_wd_nxt;
    logic          r_start, w_start_nxt;
    logic          r_cancel, w_cancel_nxt;
    logic          r_online, w_online_nxt;
    logic          r_reject, w_reject_nxt;
    logic          r_sel_err, w_sel_err_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_fault, w_fault_nxt;

    logic          w_pay_load;
    logic [6:0]    w_refund;
    logic          w_pay_done;
    logic          w_pay_fault;
    logic [6:0]    w_coin_val;
    logic [7:0]    w_credit_sum;
    logic          w_vm_in_prod;

    assign w_coin_val   = coin_value(i_coin_denom);
    assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_vm_in_prod = (i_vm_state >= VM_PROD_LO) && (i_vm_state <= VM_PROD_HI);

    // State and registered-output update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_code    <= 3'd0;
            r_credit  <= 7'd0;
            r_tmo     <= TMO_ZERO;
            r_wd      <= 2'd0;
            r_start   <= 1'b0;
            r_cancel  <= 1'b0;
            r_online  <= 1'b0;
            r_reject  <= 1'b0;
            r_sel_err <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_credit  <= w_credit_nxt;
            r_tmo     <= w_tmo_nxt;
            r_wd      <= w_wd_nxt;
            r_start   <= w_start_nxt;
            r_cancel  <= w_cancel_nxt;
            r_online  <= w_online_nxt;
            r_reject  <= w_reject_nxt;
            r_sel_err <= w_sel_err_nxt;
            r_busy    <= w_busy_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_credit_nxt  = r_credit;
        w_tmo_nxt     = r_tmo;
        w_wd_nxt      = r_wd;
        w_start_nxt   = 1'b0;
        w_cancel_nxt  = 1'b0;
        w_online_nxt  = r_online;
        // coins are refused and selections flagged unless a state accepts them
        w_reject_nxt  = i_coin_valid;
        w_sel_err_nxt = i_sel_valid;
        w_fault_nxt   = r_fault;
        w_pay_load    = 1'b0;
        w_refund      = 7'd0;

        case (r_state)
            ST_IDLE: begin
                if (i_sel_valid && (i_sel_code <= PROD_MAX)) begin
                    w_code_nxt    = i_sel_code;
                    w_start_nxt   = 1'b1;
                    w_sel_err_nxt = 1'b0;
                    w_state_nxt   = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_START: begin
                w_wd_nxt    = 2'd0;
                w_state_nxt = ST_WAIT_SEL;
            end

            ST_WAIT_SEL: begin
                if (w_vm_in_prod) begin
                    w_tmo_nxt   = TMO_RELOAD;
                    w_state_nxt = ST_PAY;
                end else if (r_wd == WD_LAST) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wd_nxt = r_wd + 2'd1;
                end
            end

            ST_PAY: begin
                if (i_cancel || (r_tmo == TMO_ZERO)) begin
                    // cancel wins over a coin in the same cycle; the coin is refused
                    w_cancel_nxt = 1'b1;
                    w_pay_load   = 1'b1;
                    w_refund     = r_credit;
                    w_credit_nxt = 7'd0;
                    w_online_nxt = 1'b0;
                    w_state_nxt  = ST_PAYOUT;
                end else if (i_vm_state == VM_DISPENSE) begin
                    // credit frozen; core's change becomes the refund
                    w_pay_load   = 1'b1;
                    w_refund     = i_vm_dispense ? i_vm_return_change : 7'd0;
                    w_credit_nxt = 7'd0;
                    w_online_nxt = 1'b0;
                    w_state_nxt  = ST_PAYOUT;
                end else begin
                    if (i_coin_valid && (w_credit_sum <= {1'b0, MAX_CREDIT})) begin
                        w_credit_nxt = w_credit_sum[6:0];
                        w_reject_nxt = 1'b0;
                        w_tmo_nxt    = TMO_RELOAD;
                    end else begin
                        w_tmo_nxt = r_tmo - TMO_ONE;
                    end
                    if (i_online_pay) begin
                        w_online_nxt = 1'b1;
                    end else begin
                        w_online_nxt = r_online;
                    end
                end
            end

            ST_PAYOUT: begin
                w_credit_nxt = 7'd0;
                if (w_pay_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pay_fault) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PAYOUT;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    vend_change_payout u_payout (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_pay_load),
        .i_amount    (w_refund),
        .i_chg_ready (i_chg_ready),
        .o_chg_valid (o_chg_valid),
        .o_chg_denom (o_chg_denom),
        .o_done      (w_pay_done),
        .o_fault     (w_pay_fault)
    );

    assign o_vm_start            = r_start;
    assign o_vm_cancel           = r_cancel;
    assign o_vm_product_code     = r_code;
    assign o_vm_online_payment   = r_online;
    assign o_vm_total_coin_value = r_credit;
    assign o_coin_reject         = r_reject;
    assign o_sel_error           = r_sel_err;
    assign o_busy                = r_busy;
    assign o_fault               = r_fault;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed self-checking bench for vend_session_ctrl.
module tb_vend_session_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_sel_valid = 1'b0;
    logic [2:0] i_sel_code = 3'd0;
    logic       i_coin_valid = 1'b0;
    logic [1:0] i_coin_denom = 2'd0;
    logic       i_cancel = 1'b0;
    logic       i_online_pay = 1'b0;
    logic [3:0] i_vm_state = 4'd0;
    logic       i_vm_dispense = 1'b0;
    logic [6:0] i_vm_return_change = 7'd0;
    logic       i_chg_ready = 1'b0;
    logic       o_vm_start, o_vm_cancel, o_vm_online_payment;
    logic [2:0] o_vm_product_code;
    logic [6:0] o_vm_total_coin_value;
    logic       o_coin_reject, o_sel_error, o_busy, o_chg_valid, o_fault;
    logic [1:0] o_chg_denom;

    int n_cmp = 0;
    int n_mis = 0;
    int d_cnt;
    int d_sum;
    logic [1:0] d_log [0:7];

    vend_session_ctrl #(.TIMEOUT_CYCLES(1000), .MAX_CREDIT(7'd127)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_sel_valid(i_sel_valid), .i_sel_code(i_sel_code),
        .i_coin_valid(i_coin_valid), .i_coin_denom(i_coin_denom),
        .i_cancel(i_cancel), .i_online_pay(i_online_pay),
        .i_vm_state(i_vm_state), .i_vm_dispense(i_vm_dispense),
        .i_vm_return_change(i_vm_return_change),
        .o_vm_start(o_vm_start), .o_vm_cancel(o_vm_cancel),
        .o_vm_product_code(o_vm_product_code),
        .o_vm_online_payment(o_vm_online_payment),
        .o_vm_total_coin_value(o_vm_total_coin_value),
        .o_coin_reject(o_coin_reject), .o_sel_error(o_sel_error),
        .o_busy(o_busy), .o_chg_valid(o_chg_valid), .o_chg_denom(o_chg_denom),
        .i_chg_ready(i_chg_ready), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"},  {31'd0, o_vm_start}, 32'd0);
        chk({tag, "_cancel"}, {31'd0, o_vm_cancel}, 32'd0);
        chk({tag, "_code"},   {29'd0, o_vm_product_code}, 32'd0);
        chk({tag, "_online"}, {31'd0, o_vm_online_payment}, 32'd0);
        chk({tag, "_credit"}, {25'd0, o_vm_total_coin_value}, 32'd0);
        chk({tag, "_reject"}, {31'd0, o_coin_reject}, 32'd0);
        chk({tag, "_selerr"}, {31'd0, o_sel_error}, 32'd0);
        chk({tag, "_busy"},   {31'd0, o_busy}, 32'd0);
        chk({tag, "_chgv"},   {31'd0, o_chg_valid}, 32'd0);
        chk({tag, "_chgd"},   {30'd0, o_chg_denom}, 32'd0);
        chk({tag, "_fault"},  {31'd0, o_fault}, 32'd0);
    endtask

    // Select code, pulse through START and bring core into product state -> PAY
    task automatic start_session(input logic [2:0] code);
        i_sel_valid = 1'b1;
        i_sel_code  = code;
        tick();
        i_sel_valid = 1'b0;
        chk("start_pulse", {31'd0, o_vm_start}, 32'd1);
        chk("start_busy", {31'd0, o_busy}, 32'd1);
        i_vm_state = 4'd2 + {1'b0, code};
        tick();
        chk("start_single", {31'd0, o_vm_start}, 32'd0);
        tick();
    endtask

    task automatic coin(input logic [1:0] denom);
        i_coin_valid = 1'b1;
        i_coin_denom = denom;
        tick();
        i_coin_valid = 1'b0;
    endtask

    // Accept change coins with ready high until the session ends
    task automatic drain();
        d_cnt = 0;
        d_sum = 0;
        i_chg_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (o_chg_valid) begin
                if (d_cnt < 8) d_log[d_cnt] = o_chg_denom;
                d_cnt++;
                case (o_chg_denom)
                    2'd0: d_sum += 5;
                    2'd1: d_sum += 10;
                    2'd2: d_sum += 20;
                    default: d_sum += 50;
                endcase
            end
            if (!o_busy) break;
            tick();
        end
        i_chg_ready = 1'b0;
        chk("drain_done", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk_all_zero("reset");
        i_rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // coin in IDLE is refused
        coin(2'd1);
        chk("idle_coin_reject", {31'd0, o_coin_reject}, 32'd1);
        chk("idle_coin_busy", {31'd0, o_busy}, 32'd0);
        tick();
        chk("idle_reject_pulse", {31'd0, o_coin_reject}, 32'd0);

        // code 2, 20+20, online pay, core dispenses change 5
        start_session(3'd2);
        chk("t1_code", {29'd0, o_vm_product_code}, 32'd2);
        coin(2'd2);
        chk("t1_credit20", {25'd0, o_vm_total_coin_value}, 32'd20);
        coin(2'd2);
        chk("t1_credit40", {25'd0, o_vm_total_coin_value}, 32'd40);
        chk("t1_no_reject", {31'd0, o_coin_reject}, 32'd0);
        i_online_pay = 1'b1;
        tick();
        i_online_pay = 1'b0;
        chk("t1_online_set", {31'd0, o_vm_online_payment}, 32'd1);
        i_vm_state = 4'd7;
        i_vm_dispense = 1'b1;
        i_vm_return_change = 7'd5;
        tick();
        i_vm_state = 4'd0;
        i_vm_dispense = 1'b0;
        chk("t1_online_clr", {31'd0, o_vm_online_payment}, 32'd0);
        chk("t1_credit_clr", {25'd0, o_vm_total_coin_value}, 32'd0);
        tick();
        chk("t1_chg_valid", {31'd0, o_chg_valid}, 32'd1);
        chk("t1_chg_denom", {30'd0, o_chg_denom}, 32'd0);
        chk("t1_busy_pay", {31'd0, o_busy}, 32'd1);
        i_chg_ready = 1'b1;
        tick();
        i_chg_ready = 1'b0;
        chk("t1_chg_taken", {31'd0, o_chg_valid}, 32'd0);
        drain();
        chk("t1_extra_coins", d_cnt, 32'd0);
        chk("t1_fault", {31'd0, o_fault}, 32'd0);

        // code 1, 50+50 then a 50 that would exceed the ceiling
        start_session(3'd1);
        coin(2'd3);
        coin(2'd3);
        chk("t2_credit100", {25'd0, o_vm_total_coin_value}, 32'd100);
        coin(2'd3);
        chk("t2_reject", {31'd0, o_coin_reject}, 32'd1);
        chk("t2_credit_kept", {25'd0, o_vm_total_coin_value}, 32'd100);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        chk("t2_cancel", {31'd0, o_vm_cancel}, 32'd1);
        chk("t2_reject_pulse", {31'd0, o_coin_reject}, 32'd0);
        drain();
        chk("t2_cnt", d_cnt, 32'd2);
        chk("t2_sum", d_sum, 32'd100);
        chk("t2_d0", {30'd0, d_log[0]}, 32'd3);

        // code 0, coin 5, then idle until auto-cancel
        start_session(3'd0);
        coin(2'd0);
        chk("t3_credit5", {25'd0, o_vm_total_coin_value}, 32'd5);
        repeat (999) tick();
        chk("t3_no_cancel_yet", {31'd0, o_vm_cancel}, 32'd0);
        tick();
        chk("t3_timeout_cancel", {31'd0, o_vm_cancel}, 32'd1);
        drain();
        chk("t3_cnt", d_cnt, 32'd1);
        chk("t3_denom", {30'd0, d_log[0]}, 32'd0);

        // code 3, coin with cancel in the same cycle
        start_session(3'd3);
        i_coin_valid = 1'b1;
        i_coin_denom = 2'd2;
        i_cancel = 1'b1;
        tick();
        i_coin_valid = 1'b0;
        i_cancel = 1'b0;
        chk("t4_reject", {31'd0, o_coin_reject}, 32'd1);
        chk("t4_cancel", {31'd0, o_vm_cancel}, 32'd1);
        chk("t4_credit", {25'd0, o_vm_total_coin_value}, 32'd0);
        drain();
        chk("t4_cnt", d_cnt, 32'd0);
        chk("t4_fault", {31'd0, o_fault}, 32'd0);

        // refund 85 with the hopper stalling for 3 cycles
        start_session(3'd4);
        coin(2'd3);
        coin(2'd2);
        coin(2'd1);
        coin(2'd0);
        chk("t5_credit85", {25'd0, o_vm_total_coin_value}, 32'd85);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        tick();
        chk("t5_valid", {31'd0, o_chg_valid}, 32'd1);
        chk("t5_denom", {30'd0, o_chg_denom}, 32'd3);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t5_hold_valid", {31'd0, o_chg_valid}, 32'd1);
            chk("t5_hold_denom", {30'd0, o_chg_denom}, 32'd3);
        end
        drain();
        chk("t5_cnt", d_cnt, 32'd4);
        chk("t5_d0", {30'd0, d_log[0]}, 32'd3);
        chk("t5_d1", {30'd0, d_log[1]}, 32'd2);
        chk("t5_d2", {30'd0, d_log[2]}, 32'd1);
        chk("t5_d3", {30'd0, d_log[3]}, 32'd0);
        chk("t5_sum", d_sum, 32'd85);

        // illegal code in IDLE
        i_sel_valid = 1'b1;
        i_sel_code = 3'd6;
        tick();
        i_sel_valid = 1'b0;
        chk("t6_sel_error", {31'd0, o_sel_error}, 32'd1);
        chk("t6_no_start", {31'd0, o_vm_start}, 32'd0);
        chk("t6_busy", {31'd0, o_busy}, 32'd0);
        tick();
        chk("t6_sel_error_pulse", {31'd0, o_sel_error}, 32'd0);

        // core never reaches a product state: watchdog fault after 4 cycles
        i_vm_state = 4'd0;
        i_sel_valid = 1'b1;
        i_sel_code = 3'd1;
        tick();
        i_sel_valid = 1'b0;
        tick();
        repeat (3) tick();
        chk("t7_no_fault_yet", {31'd0, o_fault}, 32'd0);
        chk("t7_busy", {31'd0, o_busy}, 32'd1);
        tick();
        chk("t7_fault", {31'd0, o_fault}, 32'd1);
        chk("t7_idle", {31'd0, o_busy}, 32'd0);

        // reset during PAYOUT clears everything
        start_session(3'd2);
        coin(2'd3);
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        tick();
        chk("t8_payout_valid", {31'd0, o_chg_valid}, 32'd1);
        i_rst = 1'b1;
        #2;
        chk_all_zero("t8_rst");
        tick();
        i_rst = 1'b0;
        i_vm_state = 4'd0;
        tick();
        chk("t8_post_busy", {31'd0, o_busy}, 32'd0);
        chk("t8_post_chgv", {31'd0, o_chg_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
